// File: rtl/tile_bram_pkg.sv
// Shared constants and parameter-legality helpers for the tile-local ping-pong
// bank store.
package tile_bram_pkg;

  localparam int LINES_PER_NV      = 4;
  localparam int DEFAULT_DEPTH     = 128 * LINES_PER_NV;
  localparam int DEFAULT_MAN_WIDTH = 256;
  localparam int DEFAULT_EXP_WIDTH = 8;

  function automatic bit legal_num_banks(input int n);
    return (n == 2) || (n == 4);
  endfunction

  function automatic bit legal_rd_latency(input int l);
    return (l == 1) || (l == 2);
  endfunction

endpackage

// File: rtl/tile_bram_bank.sv
// One simple dual-port bank: mantissa and exponent arrays with independent
// write ports, a shared read address and a registered read.
module tile_bram_bank #(
  parameter int DEPTH      = 512,
  parameter int MAN_WIDTH  = 256,
  parameter int EXP_WIDTH  = 8,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_man_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_man_wr_addr,
  input  logic [MAN_WIDTH-1:0]  i_man_wr_data,
  input  logic                  i_exp_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_exp_wr_addr,
  input  logic [EXP_WIDTH-1:0]  i_exp_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [MAN_WIDTH-1:0]  o_rd_man_data,
  output logic [EXP_WIDTH-1:0]  o_rd_exp_data
);

  logic [MAN_WIDTH-1:0] man_mem [DEPTH];
  logic [EXP_WIDTH-1:0] exp_mem [DEPTH];
  logic [MAN_WIDTH-1:0] man_rd_q;
  logic [EXP_WIDTH-1:0] exp_rd_q;

  // NOTE: the arrays carry no reset so they map onto block RAM; only the read
  // register below is cleared.
  always_ff @(posedge i_clk) begin
    if (i_man_wr_en) man_mem[i_man_wr_addr] <= i_man_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_exp_wr_en) exp_mem[i_exp_wr_addr] <= i_exp_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      man_rd_q <= '0;
      exp_rd_q <= '0;
    end else if (i_rd_en) begin
      man_rd_q <= man_mem[i_rd_addr];
      exp_rd_q <= exp_mem[i_rd_addr];
    end
  end

  assign o_rd_man_data = man_rd_q;
  assign o_rd_exp_data = exp_rd_q;

endmodule

// File: rtl/tile_bram_pingpong.sv
// Multi-bank ring buffer for one compute tile: the dispatcher fills bank[wp]
// while the compute engine reads committed bank[rp].
module tile_bram_pingpong
  import tile_bram_pkg::*;
#(
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int MAN_WIDTH  = DEFAULT_MAN_WIDTH,
  parameter int EXP_WIDTH  = DEFAULT_EXP_WIDTH,
  parameter int NUM_BANKS  = 2,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int CNT_WIDTH  = $clog2(NUM_BANKS) + 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_man_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_man_wr_addr,
  input  logic [MAN_WIDTH-1:0]  i_man_wr_data,
  input  logic                  i_exp_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_exp_wr_addr,
  input  logic [EXP_WIDTH-1:0]  i_exp_wr_data,
  input  logic                  i_wr_commit,
  output logic                  o_wr_ready,
  input  logic                  i_rd_en,
  input  logic [ADDR_WIDTH-1:0] i_rd_addr,
  output logic [MAN_WIDTH-1:0]  o_rd_man_data,
  output logic [EXP_WIDTH-1:0]  o_rd_exp_data,
  output logic                  o_rd_valid,
  input  logic                  i_rd_release,
  output logic                  o_rd_avail,
  output logic [CNT_WIDTH-1:0]  o_full_count,
  output logic                  o_err_overflow,
  output logic                  o_err_underflow
);

  localparam int PTR_W = $clog2(NUM_BANKS);

  if (!legal_num_banks(NUM_BANKS)) begin : g_bad_num_banks
    $error("tile_bram_pingpong: NUM_BANKS must be 2 or 4");
  end
  if (!legal_rd_latency(RD_LATENCY)) begin : g_bad_rd_latency
    $error("tile_bram_pingpong: RD_LATENCY must be 1 or 2");
  end

  logic [PTR_W-1:0]     wp_q, wp_d, rp_q, rp_d, sel_q;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, valid1_q;
  logic                 wr_ready, rd_avail, rd_fire, rel_ok, cmt_ok;

  logic [MAN_WIDTH-1:0] bank_man [NUM_BANKS];
  logic [EXP_WIDTH-1:0] bank_exp [NUM_BANKS];

  // Status derives only from registered count, so it moves the cycle after the cause.
  assign wr_ready = (cnt_q < CNT_WIDTH'(NUM_BANKS));
  assign rd_avail = (cnt_q != '0);
  assign rd_fire  = i_rd_en & rd_avail;
  assign rel_ok   = i_rd_release & rd_avail;
  // A legal release in the same cycle frees a slot, so a commit at full is accepted.
  assign cmt_ok   = i_wr_commit & (wr_ready | rel_ok);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wp_d  = wp_q + PTR_W'(cmt_ok);
    rp_d  = rp_q + PTR_W'(rel_ok);
    cnt_d = cnt_q + CNT_WIDTH'(cmt_ok) - CNT_WIDTH'(rel_ok);
    ovf_d = ovf_q | ((i_man_wr_en | i_exp_wr_en) & ~wr_ready) | (i_wr_commit & ~cmt_ok);
    unf_d = unf_q | ((i_rd_en | i_rd_release) & ~rd_avail);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wp_q     <= '0;
      rp_q     <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      valid1_q <= 1'b0;
      sel_q    <= '0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      valid1_q <= rd_fire;
      if (rd_fire) sel_q <= rp_q;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic wr_sel, rd_sel;
    assign wr_sel = wr_ready & (wp_q == PTR_W'(b));
    assign rd_sel = rd_fire & (rp_q == PTR_W'(b));

    tile_bram_bank #(
      .DEPTH(DEPTH), .MAN_WIDTH(MAN_WIDTH), .EXP_WIDTH(EXP_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)
    ) u_bank (
      .i_clk         (i_clk),
      .i_reset       (i_reset),
      .i_man_wr_en   (i_man_wr_en & wr_sel),
      .i_man_wr_addr (i_man_wr_addr),
      .i_man_wr_data (i_man_wr_data),
      .i_exp_wr_en   (i_exp_wr_en & wr_sel),
      .i_exp_wr_addr (i_exp_wr_addr),
      .i_exp_wr_data (i_exp_wr_data),
      .i_rd_en       (rd_sel),
      .i_rd_addr     (i_rd_addr),
      .o_rd_man_data (bank_man[b]),
      .o_rd_exp_data (bank_exp[b])
    );
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic [MAN_WIDTH-1:0] man_out_q;
    logic [EXP_WIDTH-1:0] exp_out_q;
    logic                 valid2_q;

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        man_out_q <= '0;
        exp_out_q <= '0;
        valid2_q  <= 1'b0;
      end else begin
        valid2_q <= valid1_q;
        if (valid1_q) begin
          man_out_q <= bank_man[sel_q];
          exp_out_q <= bank_exp[sel_q];
        end
      end
    end

    assign o_rd_man_data = man_out_q;
    assign o_rd_exp_data = exp_out_q;
    assign o_rd_valid    = valid2_q;
  end else begin : g_lat1
    // Bank read registers and sel_q only change on a read, so data holds between reads.
    assign o_rd_man_data = bank_man[sel_q];
    assign o_rd_exp_data = bank_exp[sel_q];
    assign o_rd_valid    = valid1_q;
  end

  assign o_wr_ready      = wr_ready;
  assign o_rd_avail      = rd_avail;
  assign o_full_count    = cnt_q;
  assign o_err_overflow  = ovf_q;
  assign o_err_underflow = unf_q;

endmodule

// File: tb/tb_tile_bram_pingpong.sv
// Scoreboard bench for tile_bram_pingpong: directed fill/read, overlap,
// overflow, underflow, simultaneous commit/release and mid-read reset.
module tb_tile_bram_pingpong;

  localparam int LAT = 1;
  localparam int AW  = 9;
  localparam int MW  = 256;
  localparam int EW  = 8;
  localparam int CW  = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          man_wr_en, exp_wr_en, commit, rd_en, rel;
  logic [AW-1:0] man_wr_addr, exp_wr_addr, rd_addr;
  logic [MW-1:0] man_wr_data, rd_man;
  logic [EW-1:0] exp_wr_data, rd_exp;
  logic          wr_ready, rd_valid, rd_avail, err_ovf, err_unf;
  logic [CW-1:0] full_count;

  always #5 clk = ~clk;

  tile_bram_pingpong #(.NUM_BANKS(2), .RD_LATENCY(LAT)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_man_wr_en(man_wr_en), .i_man_wr_addr(man_wr_addr), .i_man_wr_data(man_wr_data),
    .i_exp_wr_en(exp_wr_en), .i_exp_wr_addr(exp_wr_addr), .i_exp_wr_data(exp_wr_data),
    .i_wr_commit(commit), .o_wr_ready(wr_ready),
    .i_rd_en(rd_en), .i_rd_addr(rd_addr),
    .o_rd_man_data(rd_man), .o_rd_exp_data(rd_exp), .o_rd_valid(rd_valid),
    .i_rd_release(rel), .o_rd_avail(rd_avail), .o_full_count(full_count),
    .o_err_overflow(err_ovf), .o_err_underflow(err_unf)
  );

  typedef struct {
    logic [MW-1:0] man;
    logic [EW-1:0] exp;
    int            due;
  } rd_exp_t;

  rd_exp_t sb[$];
  int n_cmp = 0;
  int n_err = 0;
  int edge_cnt = 0;

  always @(posedge clk) edge_cnt++;

  function automatic logic [MW-1:0] man_pat(input int a, input logic [7:0] salt);
    logic [15:0] w;
    w = 16'(a) ^ {salt, salt};
    return {16{w}};
  endfunction

  function automatic logic [EW-1:0] exp_pat(input int a, input logic [7:0] salt);
    return 8'(a) ^ salt;
  endfunction

  task automatic check(input string name, input logic [MW-1:0] act, input logic [MW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    man_wr_en = 1'b0; exp_wr_en = 1'b0; commit = 1'b0; rd_en = 1'b0; rel = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic wr(input int a, input logic [7:0] salt);
    man_wr_en = 1'b1; man_wr_addr = AW'(a); man_wr_data = man_pat(a, salt);
    exp_wr_en = 1'b1; exp_wr_addr = AW'(a); exp_wr_data = exp_pat(a, salt);
  endtask

  task automatic rd(input int a, input logic [7:0] salt, input bit expect_data);
    rd_exp_t e;
    rd_en = 1'b1; rd_addr = AW'(a);
    if (expect_data) begin
      e.man = man_pat(a, salt);
      e.exp = exp_pat(a, salt);
      e.due = edge_cnt + LAT;
      sb.push_back(e);
    end
  endtask

  // Monitor: every valid beat must match the oldest expectation, on its due edge.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("rd_valid_unexpected", rd_valid, 0);
      end else begin
        rd_exp_t e;
        e = sb.pop_front();
        check("rd_man", rd_man, e.man);
        check("rd_exp", rd_exp, e.exp);
        check("rd_latency_edge", edge_cnt, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    man_wr_en = 0; exp_wr_en = 0; commit = 0; rd_en = 0; rel = 0;
    man_wr_addr = '0; exp_wr_addr = '0; rd_addr = '0;
    man_wr_data = '0; exp_wr_data = '0;
    step(); step();
    rst = 1'b0;

    check("rst_count", full_count, 0);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_rd_avail", rd_avail, 0);
    check("rst_ovf", err_ovf, 0);
    check("rst_unf", err_unf, 0);
    check("rst_valid", rd_valid, 0);
    check("rst_man", rd_man, 0);
    check("rst_exp", rd_exp, 0);

    // Fill bank 0; the last line is written in the commit cycle itself.
    for (int a = 0; a < 511; a++) begin wr(a, 8'h00); step(); end
    wr(511, 8'h00); commit = 1'b1; step();
    check("fill_count", full_count, 1);
    check("fill_avail", rd_avail, 1);
    check("fill_wr_ready", wr_ready, 1);

    // Read bank 0 at full rate while filling bank 1.
    for (int a = 0; a < 512; a++) begin
      rd(a, 8'h00, 1'b1);
      wr(a, 8'hA5);
      if (a == 511) commit = 1'b1;
      step();
    end
    check("ovl_count2", full_count, 2);
    check("ovl_wr_ready0", wr_ready, 0);

    // Overflow: third commit and a write while full are both dropped.
    commit = 1'b1; step();
    check("ovf_count", full_count, 2);
    check("ovf_flag", err_ovf, 1);
    wr(0, 8'hFF); step();
    check("ovf_wr_ready", wr_ready, 0);

    rel = 1'b1; step();
    check("ovl_count1", full_count, 1);
    check("ovl_wr_ready1", wr_ready, 1);
    check("ovl_unf", err_unf, 0);

    rd(0, 8'hA5, 1'b1); step();
    rd(255, 8'hA5, 1'b1); step();
    rd(511, 8'hA5, 1'b1); rel = 1'b0; step();
    rel = 1'b1; step();
    check("drain_count", full_count, 0);
    check("drain_avail", rd_avail, 0);
    step(); step();

    // Re-commit bank 0 unwritten: line 0 must still hold the original pattern.
    commit = 1'b1; step();
    rd(0, 8'h00, 1'b1); step();
    rd(511, 8'h00, 1'b1); step();
    rel = 1'b1; step();

    // Simultaneous commit and release at full.
    do_reset();
    check("rst2_ovf", err_ovf, 0);
    commit = 1'b1; step();
    commit = 1'b1; step();
    check("sim_pre_count", full_count, 2);
    commit = 1'b1; rel = 1'b1; step();
    check("sim_count", full_count, 2);
    check("sim_ovf", err_ovf, 0);
    check("sim_unf", err_unf, 0);
    rd(5, 8'hA5, 1'b1); step();          // rp advanced to bank 1
    rel = 1'b1; step();                  // rp -> 0, count 1
    wr(7, 8'h3C); step();                // wp is 1: bank 1
    rd(7, 8'h00, 1'b1); step();          // bank 0 unaffected
    commit = 1'b1; step();
    rel = 1'b1; step();
    rd(7, 8'h3C, 1'b1); step();
    check("sim_end_count", full_count, 1);

    // Underflow at empty.
    do_reset();
    rd(2, 8'h00, 1'b0); rel = 1'b1; step();
    check("unf_count", full_count, 0);
    check("unf_flag", err_unf, 1);
    check("unf_ovf", err_ovf, 0);
    step(); step();
    commit = 1'b1; rel = 1'b1; step();
    check("unf_cmt_count", full_count, 1);
    check("unf_cmt_flag", err_unf, 1);

    // Reset one cycle after a read: in-flight data dropped, outputs cleared.
    rd(3, 8'h00, LAT == 1); step();
    do_reset();
    check("mrst_valid", rd_valid, 0);
    check("mrst_count", full_count, 0);
    check("mrst_man", rd_man, 0);
    check("mrst_exp", rd_exp, 0);
    check("mrst_unf", err_unf, 0);
    check("mrst_avail", rd_avail, 0);
    step();
    check("mrst_valid_late", rd_valid, 0);

    commit = 1'b1; step();
    rd(3, 8'h00, 1'b1); step();
    rd(100, 8'h00, 1'b1); step();
    rel = 1'b1; step();
    for (int i = 0; i < 4; i++) step();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
